// File: rtl/led_flow_pkg.sv
// -----------------------------------------------------------------------------
// led_flow_pkg
// Shared types and constants for the flow-LED run-time controller:
//   - mode encodings and their start patterns
//   - ping-pong direction encoding
//   - field widths for mode and speed
// -----------------------------------------------------------------------------
package led_flow_pkg;

  localparam int MODE_W  = 2;
  localparam int SPEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHIFT_L   = 2'd0,
    MODE_SHIFT_R   = 2'd1,
    MODE_PING_PONG = 2'd2,
    MODE_BLINK     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [7:0] PAT_SHIFT_L   = 8'h01;
  localparam logic [7:0] PAT_SHIFT_R   = 8'h80;
  localparam logic [7:0] PAT_PING_PONG = 8'h01;
  localparam logic [7:0] PAT_BLINK     = 8'hFF;

  // Pattern loaded into the LEDs when a mode is entered.
  function automatic logic [7:0] start_pattern(input mode_e m);
    logic [7:0] pat;
    case (m)
      MODE_SHIFT_L:   pat = PAT_SHIFT_L;
      MODE_SHIFT_R:   pat = PAT_SHIFT_R;
      MODE_PING_PONG: pat = PAT_PING_PONG;
      MODE_BLINK:     pat = PAT_BLINK;
      default:        pat = PAT_SHIFT_L;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Brings one raw active-low key into the clock domain and debounces it. A new
// level is accepted only after the synchronised input has disagreed with the
// accepted level for DEBOUNCE_MAX consecutive cycles; any agreeing sample
// restarts the count. An accepted released->pressed change gives a one-cycle
// press pulse (no auto-repeat).
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset
//   key_n_i  in   raw key, active-low, asynchronous
//   press_o  out  registered one-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q, level_d;
  logic [19:0] cnt_q,   cnt_d;
  logic        press_q, press_d;

  // Debounce counter and level acceptance.
  always_comb begin
    cnt_d   = 20'd0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_MAX - 20'd1) begin
        // This is the DEBOUNCE_MAX-th disagreeing sample: accept it.
        level_d = sync2_q;
        press_d = ~sync2_q;
        cnt_d   = 20'd0;
      end else begin
        cnt_d   = cnt_q + 20'd1;
      end
    end else begin
      cnt_d = 20'd0;
    end
  end

  // Synchroniser and debounce state; idle state is "released".
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= 20'd0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_flow_ctrl.sv
// -----------------------------------------------------------------------------
// led_flow_ctrl
// Run-time controller for the 8-bit flow LEDs: step-period counter, four LED
// patterns (shift left, shift right, ping-pong, blink), and mode / speed /
// pause keys through per-key debouncers.
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   synchronous active-low reset
//   key_mode_n   in   raw mode key (active-low)
//   key_speed_n  in   raw speed key (active-low)
//   key_pause_n  in   raw pause key (active-low)
//   led_out      out  LED pattern
//   mode         out  current mode
//   speed        out  current speed level (period = CNT_MAX >> speed)
//   paused       out  stepping frozen
//   tick         out  one-cycle pulse, high with each new pattern
// -----------------------------------------------------------------------------
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter logic [23:0] CNT_MAX      = 24'd1000_0000,
  parameter logic [19:0] DEBOUNCE_MAX = 20'd1_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               key_mode_n,
  input  logic               key_speed_n,
  input  logic               key_pause_n,
  output logic [7:0]         led_out,
  output logic [MODE_W-1:0]  mode,
  output logic [SPEED_W-1:0] speed,
  output logic               paused,
  output logic               tick
);

  logic               press_mode_s, press_speed_s, press_pause_s;
  logic               any_press_s, step_s;
  logic [23:0]        period_s;

  logic [23:0]        cnt_q,    cnt_d;
  mode_e              mode_q,   mode_d;
  logic [SPEED_W-1:0] speed_q,  speed_d;
  logic               paused_q, paused_d;
  dir_e               dir_q,    dir_d;
  logic [7:0]         led_q,    led_d;
  logic               tick_q,   tick_d;

  key_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key_mode (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .key_n_i(key_mode_n),  .press_o(press_mode_s)
  );
  key_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key_speed (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .key_n_i(key_speed_n), .press_o(press_speed_s)
  );
  key_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key_pause (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .key_n_i(key_pause_n), .press_o(press_pause_s)
  );

  assign period_s    = CNT_MAX >> speed_q;
  assign any_press_s = press_mode_s | press_speed_s | press_pause_s;
  // A press restarts the period, so it also swallows a step due this cycle.
  assign step_s      = !paused_q && !any_press_s && (cnt_q == period_s);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q    <= 24'd0;
      mode_q   <= MODE_SHIFT_L;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      dir_q    <= DIR_LEFT;
      led_q    <= 8'h01;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end

  // Next state: counter, mode/speed/pause, ping-pong direction.
  always_comb begin
    mode_d   = press_mode_s  ? mode_e'(mode_q + 2'd1) : mode_q;
    speed_d  = press_speed_s ? speed_q + 2'd1 : speed_q;
    paused_d = paused_q ^ press_pause_s;

    if (any_press_s) begin
      cnt_d = 24'd0;
    end else if (paused_q) begin
      cnt_d = cnt_q;
    end else if (cnt_q == period_s) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end

    if (press_mode_s) begin
      dir_d = DIR_LEFT;
    end else if (step_s && mode_q == MODE_PING_PONG) begin
      if (dir_q == DIR_LEFT && led_q == 8'h80) begin
        dir_d = DIR_RIGHT;
      end else if (dir_q == DIR_RIGHT && led_q == 8'h01) begin
        dir_d = DIR_LEFT;
      end else begin
        dir_d = dir_q;
      end
    end else begin
      dir_d = dir_q;
    end
  end

  // Outputs: pattern for the next cycle and the tick that marks it.
  always_comb begin
    tick_d = step_s;
    if (press_mode_s) begin
      // Load uses the incremented mode so simultaneous presses stay coherent.
      led_d = start_pattern(mode_d);
    end else if (step_s) begin
      case (mode_q)
        MODE_SHIFT_L:   led_d = {led_q[6:0], led_q[7]};
        MODE_SHIFT_R:   led_d = {led_q[0], led_q[7:1]};
        MODE_PING_PONG: begin
          if (dir_q == DIR_LEFT) begin
            led_d = (led_q == 8'h80) ? 8'h40 : {led_q[6:0], 1'b0};
          end else begin
            led_d = (led_q == 8'h01) ? 8'h02 : {1'b0, led_q[7:1]};
          end
        end
        MODE_BLINK:     led_d = ~led_q;
        default:        led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
  end

  assign led_out = led_q;
  assign mode    = mode_q;
  assign speed   = speed_q;
  assign paused  = paused_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_flow_ctrl
// Directed bench for led_flow_ctrl with CNT_MAX=16, DEBOUNCE_MAX=4.
// -----------------------------------------------------------------------------
module tb_led_flow_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_mode_n, key_speed_n, key_pause_n;
  logic [7:0] led_out;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;
  logic       tick;

  int n_asserts = 0;
  int n_fails   = 0;

  led_flow_ctrl #(
    .CNT_MAX(24'd16),
    .DEBOUNCE_MAX(20'd4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_mode_n(key_mode_n),
    .key_speed_n(key_speed_n),
    .key_pause_n(key_pause_n),
    .led_out(led_out),
    .mode(mode),
    .speed(speed),
    .paused(paused),
    .tick(tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; sample 1 time unit after the active edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step until tick is seen; n = cycles taken. Timeout is a failed check.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < max);
    check("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  // which: 0 mode, 1 speed, 2 pause. Low 8 cycles, then released 8 cycles.
  task automatic press(input int which);
    if (which == 0) key_mode_n = 1'b0;
    else if (which == 1) key_speed_n = 1'b0;
    else key_pause_n = 1'b0;
    repeat (8) step();
    key_mode_n  = 1'b1;
    key_speed_n = 1'b1;
    key_pause_n = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int n;
    logic [7:0] e;
    logic [7:0] saved;
    logic [7:0] pp_tab [15];
    pp_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // ---- 1: reset and free-running shift left -------------------------
    sys_rst_n   = 1'b0;
    key_mode_n  = 1'b1;
    key_speed_n = 1'b1;
    key_pause_n = 1'b1;
    step();
    step();
    check("rst_led",    {24'd0, led_out}, 32'h01);
    check("rst_mode",   {30'd0, mode},    32'd0);
    check("rst_speed",  {30'd0, speed},   32'd0);
    check("rst_paused", {31'd0, paused},  32'd0);
    check("rst_tick",   {31'd0, tick},    32'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("idle_tick", {31'd0, tick},    32'd0);
      check("idle_led",  {24'd0, led_out}, 32'h01);
    end
    step();
    check("first_tick", {31'd0, tick},    32'd1);
    check("first_led",  {24'd0, led_out}, 32'h02);
    e = 8'h02;
    for (int k = 2; k <= 8; k++) begin
      wait_tick(40, n);
      e = {e[6:0], e[7]};
      check("shl_period", n, 32'd17);
      check("shl_led", {24'd0, led_out}, {24'd0, e});
    end
    check("shl_wrap_led", {24'd0, led_out}, 32'h01);

    // ---- 2: speed levels ----------------------------------------------
    press(1);
    check("speed1", {30'd0, speed}, 32'd1);
    wait_tick(40, n);
    wait_tick(40, n);
    check("speed1_period", n, 32'd9);
    press(1);
    press(1);
    press(1);
    check("speed_wrap", {30'd0, speed}, 32'd0);
    wait_tick(40, n);
    wait_tick(40, n);
    check("speed0_period", n, 32'd17);

    // ---- 3: shift right -----------------------------------------------
    press(0);
    check("mode1", {30'd0, mode}, 32'd1);
    check("mode1_start", {24'd0, led_out}, 32'h80);
    wait_tick(40, n);
    check("shr_led0", {24'd0, led_out}, 32'h40);
    wait_tick(40, n);
    check("shr_led1", {24'd0, led_out}, 32'h20);
    check("shr_period", n, 32'd17);
    wait_tick(40, n);
    check("shr_led2", {24'd0, led_out}, 32'h10);

    // ---- 4: ping-pong then blink --------------------------------------
    press(0);
    check("mode2", {30'd0, mode}, 32'd2);
    check("mode2_start", {24'd0, led_out}, 32'h01);
    for (int k = 0; k < 15; k++) begin
      wait_tick(40, n);
      check("pp_led", {24'd0, led_out}, {24'd0, pp_tab[k]});
    end
    press(0);
    check("mode3", {30'd0, mode}, 32'd3);
    check("mode3_start", {24'd0, led_out}, 32'hFF);
    wait_tick(40, n);
    check("blink0", {24'd0, led_out}, 32'h00);
    wait_tick(40, n);
    check("blink1", {24'd0, led_out}, 32'hFF);

    // ---- 5: bounce rejection and single press on long hold ------------
    for (int r = 0; r < 5; r++) begin
      key_mode_n = 1'b0;
      repeat (3) step();
      key_mode_n = 1'b1;
      repeat (3) step();
    end
    repeat (10) step();
    check("bounce_mode", {30'd0, mode}, 32'd3);
    key_mode_n = 1'b0;
    repeat (100) step();
    key_mode_n = 1'b1;
    repeat (10) step();
    check("hold_mode", {30'd0, mode}, 32'd0);

    // ---- 6: pause, speed while paused, unpause, mid-run reset ---------
    press(2);
    check("paused_on", {31'd0, paused}, 32'd1);
    saved = led_out;
    for (int i = 0; i < 200; i++) begin
      step();
      check("paused_tick", {31'd0, tick},    32'd0);
      check("paused_led",  {24'd0, led_out}, {24'd0, saved});
    end
    press(1);
    check("paused_speed", {30'd0, speed},   32'd1);
    check("paused_still", {31'd0, paused},  32'd1);
    check("paused_led2",  {24'd0, led_out}, {24'd0, saved});
    key_pause_n = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (paused !== 1'b0 && n < 30);
    check("paused_off", {31'd0, paused}, 32'd0);
    wait_tick(40, n);
    check("unpause_period", n, 32'd9);
    check("unpause_led", {24'd0, led_out}, {24'd0, saved[6:0], saved[7]});
    key_pause_n = 1'b1;
    repeat (5) step();
    sys_rst_n = 1'b0;
    step();
    check("mid_rst_led",    {24'd0, led_out}, 32'h01);
    check("mid_rst_mode",   {30'd0, mode},    32'd0);
    check("mid_rst_speed",  {30'd0, speed},   32'd0);
    check("mid_rst_paused", {31'd0, paused},  32'd0);
    check("mid_rst_tick",   {31'd0, tick},    32'd0);
    sys_rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
